// File: rtl/axis_1553_decoder.sv
// MIL-STD-1553 Manchester II receiver: finds the 3 us sync, decodes 16 data bits
// plus odd parity and presents each word as a single AXI-Stream beat.
module axis_1553_decoder #(
  parameter int clock_speed = 20000000
) (
  input  logic        aclk,
  input  logic        arstn,
  input  logic [1:0]  diff,
  output logic [15:0] m_axis_tdata,
  output logic [7:0]  m_axis_tuser,
  output logic        m_axis_tvalid,
  input  logic        m_axis_tready
);

  localparam int BIT  = clock_speed / 1000000;
  localparam int HALF = BIT / 2;
  localparam int CW   = $clog2(4 * BIT);

  localparam logic [CW-1:0] S1_MIN  = CW'(5 * BIT / 4);
  localparam logic [CW-1:0] S1_MAX  = CW'(7 * BIT / 4);
  localparam logic [CW-1:0] S2_END  = CW'(3 * HALF - 1);
  localparam logic [CW-1:0] SMP1    = CW'(HALF / 2);
  localparam logic [CW-1:0] SMP2    = CW'(HALF + HALF / 2);
  localparam logic [CW-1:0] BIT_END = CW'(BIT - 1);

  typedef enum logic [2:0] {IDLE, SYNC1, SYNC2, DATA, DONE} state_t;

  logic [1:0]    meta, lvl, prev;
  logic          is_hi, is_lo, is_idle, accept;
  state_t        state;
  logic [CW-1:0] cnt;
  logic [4:0]    bit_idx;
  logic [15:0]   shreg;
  logic          rec_hi, first_smp, man_err, par_err, ovf;

  assign is_hi   = (lvl == 2'b10);
  assign is_lo   = (lvl == 2'b01);
  assign is_idle = !(is_hi || is_lo);
  assign accept  = m_axis_tvalid && m_axis_tready;

  always_ff @(posedge aclk) begin
    if (!arstn) begin
      meta <= 2'b00;
      lvl  <= 2'b00;
      prev <= 2'b00;
    end else begin
      meta <= diff;
      lvl  <= meta;
      prev <= lvl;
    end
  end

  always_ff @(posedge aclk) begin
    if (!arstn) begin
      state         <= IDLE;
      cnt           <= '0;
      bit_idx       <= '0;
      shreg         <= '0;
      rec_hi        <= 1'b0;
      first_smp     <= 1'b0;
      man_err       <= 1'b0;
      par_err       <= 1'b0;
      ovf           <= 1'b0;
      m_axis_tvalid <= 1'b0;
      m_axis_tdata  <= '0;
      m_axis_tuser  <= '0;
    end else begin
      if (accept)
        m_axis_tvalid <= 1'b0;

      case (state)
        IDLE: begin
          if (lvl != prev && !is_idle) begin
            rec_hi  <= is_hi;
            cnt     <= '0;
            bit_idx <= '0;
            man_err <= 1'b0;
            state   <= SYNC1;
          end
        end

        SYNC1: begin
          if (is_idle) begin
            state <= IDLE;
          end else if (is_hi == rec_hi) begin
            // Give up as soon as the first half is too long to ever qualify.
            if (cnt > S1_MAX)
              state <= IDLE;
            else
              cnt <= cnt + CW'(1);
          end else if (cnt >= S1_MIN && cnt <= S1_MAX) begin
            cnt   <= CW'(1);
            state <= SYNC2;
          end else begin
            state <= IDLE;
          end
        end

        SYNC2: begin
          if (is_idle) begin
            state <= IDLE;
          end else if (cnt == S2_END) begin
            cnt   <= '0;
            state <= DATA;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end

        DATA: begin
          if (is_idle) begin
            state <= IDLE;
          end else begin
            if (cnt == SMP1)
              first_smp <= is_hi;
            if (cnt == SMP2) begin
              if (first_smp == is_hi)
                man_err <= 1'b1;
              if (bit_idx < 5'd16) begin
                shreg <= {shreg[14:0], first_smp};
              end else begin
                par_err <= ~(^shreg ^ first_smp);
                state   <= DONE;
              end
            end
            if (cnt == BIT_END) begin
              cnt     <= '0;
              bit_idx <= bit_idx + 5'd1;
            end else begin
              cnt <= cnt + CW'(1);
            end
          end
        end

        DONE: begin
          state <= IDLE;
          // A slot freed by this clock's handshake may take the new word.
          if (!m_axis_tvalid || m_axis_tready) begin
            m_axis_tvalid <= 1'b1;
            m_axis_tdata  <= shreg;
            m_axis_tuser  <= {rec_hi, ~rec_hi, 3'b000, ovf, par_err, man_err};
            ovf           <= 1'b0;
          end else begin
            ovf <= 1'b1;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule
